// File: rtl/cuthrough_output_arbiter.sv
// Cut-through output-port arbiter: round-robin packet lock across router inputs
// feeding one registered AXI-Stream output with full-throughput skid-free forwarding.
module cuthrough_output_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int CHANNEL_NUMBER = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CHANNEL_NUMBER-1:0]          in_request,
  input  logic [CHANNEL_NUMBER-1:0]          in_tvalid,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0] in_tid,
  input  logic [CHANNEL_NUMBER-1:0]          in_tlast,
  output logic [CHANNEL_NUMBER-1:0]          in_tready,
  output logic                               out_tvalid,
  output logic [DATA_WIDTH-1:0]              out_tdata,
  output logic [ID_WIDTH-1:0]                out_tid,
  output logic                               out_tlast,
  input  logic                               out_tready,
  output logic [CHANNEL_NUMBER-1:0]          grant,
  output logic                               locked
);

  localparam int PTR_W = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t                    r_state;
  logic [PTR_W-1:0]          r_rr_ptr;
  logic [PTR_W-1:0]          r_gidx;
  logic [CHANNEL_NUMBER-1:0] r_grant;
  logic                      r_locked;
  logic                      r_out_tvalid;
  logic [DATA_WIDTH-1:0]     r_out_tdata;
  logic [ID_WIDTH-1:0]       r_out_tid;
  logic                      r_out_tlast;

  logic [CHANNEL_NUMBER-1:0] w_cand;
  logic [CHANNEL_NUMBER-1:0] w_win_onehot;
  logic [PTR_W-1:0]          w_win_idx;
  logic                      w_win_found;
  logic                      w_out_free;
  logic                      w_xfer;
  logic                      w_xfer_last;
  logic [DATA_WIDTH-1:0]     w_sel_tdata;
  logic [ID_WIDTH-1:0]       w_sel_tid;
  logic                      w_sel_tlast;

  assign w_cand     = in_request & in_tvalid;
  assign w_out_free = !r_out_tvalid || out_tready;

  // Rotating search: the input just after the last winner has top priority.
  always_comb begin
    int idx;
    idx         = 0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= CHANNEL_NUMBER; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= CHANNEL_NUMBER) idx = idx - CHANNEL_NUMBER;
      if (!w_win_found && w_cand[idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = PTR_W'(idx);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUMBER; gi++) begin : g_chan
      assign w_win_onehot[gi] = w_win_found && (w_win_idx == PTR_W'(gi));
      // r_grant is zero outside LOCKED, so only the owner can ever see ready.
      assign in_tready[gi]    = r_grant[gi] && w_out_free;
    end
  endgenerate

  always_comb begin
    w_sel_tdata = '0;
    w_sel_tid   = '0;
    w_sel_tlast = 1'b0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (r_grant[i]) begin
        w_sel_tdata = w_sel_tdata | in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_tid   = w_sel_tid   | in_tid[i*ID_WIDTH +: ID_WIDTH];
        w_sel_tlast = w_sel_tlast | in_tlast[i];
      end
    end
  end

  assign w_xfer      = |(in_tvalid & in_tready);
  assign w_xfer_last = w_xfer && w_sel_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= PTR_W'(CHANNEL_NUMBER - 1);
      r_gidx       <= '0;
      r_grant      <= '0;
      r_locked     <= 1'b0;
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tid    <= '0;
      r_out_tlast  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_state  <= S_LOCKED;
            r_grant  <= w_win_onehot;
            r_gidx   <= w_win_idx;
            r_locked <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_xfer_last) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= r_gidx;
            r_locked <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Output stage drains on its own; a load wins over a drain in the same cycle.
      if (w_xfer) begin
        r_out_tvalid <= 1'b1;
        r_out_tdata  <= w_sel_tdata;
        r_out_tid    <= w_sel_tid;
        r_out_tlast  <= w_sel_tlast;
      end else if (out_tready) begin
        r_out_tvalid <= 1'b0;
      end
    end
  end

  assign out_tvalid = r_out_tvalid;
  assign out_tdata  = r_out_tdata;
  assign out_tid    = r_out_tid;
  assign out_tlast  = r_out_tlast;
  assign grant      = r_grant;
  assign locked     = r_locked;

endmodule

// File: tb/tb_cuthrough_output_arbiter.sv
// Directed bench for cuthrough_output_arbiter: packet sources, output capture and
// hand-computed grant/stream expectations checked with immediate assertions.
module tb_cuthrough_output_arbiter;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int N  = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_request, in_tvalid, in_tlast, in_tready, grant;
  logic [N*DW-1:0] in_tdata;
  logic [N*IW-1:0] in_tid;
  logic            out_tvalid, out_tlast, out_tready, locked;
  logic [DW-1:0]   out_tdata;
  logic [IW-1:0]   out_tid;

  cuthrough_output_arbiter #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_request(in_request), .in_tvalid(in_tvalid), .in_tdata(in_tdata),
    .in_tid(in_tid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tid(out_tid),
    .out_tlast(out_tlast), .out_tready(out_tready),
    .grant(grant), .locked(locked)
  );

  always #5 clk = ~clk;

  int            src_len[N], src_pkts[N], src_flit[N], src_pktno[N];
  logic [N-1:0]  req_en, val_en;
  logic [DW-1:0] cap_q[$];
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  gnt_log[$];
  logic [N-1:0]  prev_grant;
  int            locked_cycles;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [DW-1:0] flit_word(int i, int p, int f);
    return DW'((i << 24) | (p << 8) | f);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic act;
    for (int i = 0; i < N; i++) begin
      act                 = src_pkts[i] > 0;
      in_request[i]       = act && req_en[i];
      in_tvalid[i]        = act && val_en[i];
      in_tdata[i*DW +: DW] = act ? flit_word(i, src_pktno[i], src_flit[i]) : '0;
      in_tid[i*IW +: IW]  = IW'(i);
      in_tlast[i]         = act && (src_flit[i] == src_len[i] - 1);
    end
  endtask

  task automatic add_src(int i, int len, int pkts);
    src_len[i]   = len;
    src_pkts[i]  = pkts;
    src_flit[i]  = 0;
    src_pktno[i] = 0;
    drive();
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_pkts[i] = 0; src_flit[i] = 0; src_pktno[i] = 0;
    end
    req_en = '1;
    val_en = '1;
    drive();
  endtask

  // One clock: sample handshakes at the falling edge, advance sources after the rising edge.
  task automatic cycle();
    logic [N-1:0]  hs;
    logic          ohs;
    logic [DW-1:0] od;
    @(negedge clk);
    hs  = in_tvalid & in_tready;
    ohs = out_tvalid & out_tready;
    od  = out_tdata;
    @(posedge clk);
    #1;
    if (ohs) cap_q.push_back(od);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        src_flit[i]++;
        if (src_flit[i] == src_len[i]) begin
          src_flit[i] = 0;
          src_pkts[i]--;
          src_pktno[i]++;
        end
      end
    end
    if (grant != '0 && prev_grant == '0) gnt_log.push_back(grant);
    prev_grant = grant;
    if (locked) locked_cycles++;
    drive();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_locked"}, 64'(locked), 64'(0));
    chk({tag, "_otvalid"}, 64'(out_tvalid), 64'(0));
    chk({tag, "_otdata"}, 64'(out_tdata), 64'(0));
    chk({tag, "_otid"}, 64'(out_tid), 64'(0));
    chk({tag, "_otlast"}, 64'(out_tlast), 64'(0));
    chk({tag, "_itready"}, 64'(in_tready), 64'(0));
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    out_tready = 1'b1;
    clear_src();
    cap_q.delete();
    exp_q.delete();
    gnt_log.delete();
    prev_grant = '0;
    #1;
    chk_zero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    locked_cycles = 0;
  endtask

  task automatic chk_stream(string tag);
    logic [DW-1:0] obs;
    chk({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      obs = (k < cap_q.size()) ? cap_q[k] : '1;
      chk($sformatf("%s_flit%0d", tag, k), 64'(obs), 64'(exp_q[k]));
    end
  endtask

  initial begin
    int order[3];
    order = '{1, 3, 4};

    // Two contenders after reset: input 0 first, input 2 after one bubble
    do_reset("rstA");
    add_src(0, 3, 1);
    add_src(2, 3, 1);
    cycle();
    chk("A_grant0", 64'(grant), 64'(5'b00001));
    chk("A_locked", 64'(locked), 64'(1));
    chk("A_tready0", 64'(in_tready), 64'(5'b00001));
    cycle(); cycle(); cycle();
    chk("A_rel_grant", 64'(grant), 64'(0));
    chk("A_rel_locked", 64'(locked), 64'(0));
    chk("A_rel_tready", 64'(in_tready), 64'(0));
    chk("A_rel_otvalid", 64'(out_tvalid), 64'(1));
    chk("A_rel_otlast", 64'(out_tlast), 64'(1));
    chk("A_rel_otdata", 64'(out_tdata), 64'(flit_word(0, 0, 2)));
    cycle();
    chk("A_grant2", 64'(grant), 64'(5'b00100));
    repeat (8) cycle();
    for (int f = 0; f < 3; f++) exp_q.push_back(flit_word(0, 0, f));
    for (int f = 0; f < 3; f++) exp_q.push_back(flit_word(2, 0, f));
    chk_stream("A");

    // Round robin among 1, 3, 4 with back-to-back 2-flit packets
    do_reset("rstB");
    add_src(1, 2, 2);
    add_src(3, 2, 2);
    add_src(4, 2, 2);
    repeat (25) cycle();
    chk("B_gnt_count", 64'(gnt_log.size()), 64'(6));
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] g;
      g = (k < gnt_log.size()) ? gnt_log[k] : '0;
      chk($sformatf("B_gnt%0d", k), 64'(g), 64'(5'b00001 << order[k % 3]));
    end
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 3; j++)
        for (int f = 0; f < 2; f++) exp_q.push_back(flit_word(order[j], p, f));
    chk_stream("B");

    // Downstream stall for 5 cycles mid-packet
    do_reset("rstC");
    add_src(0, 4, 1);
    cycle(); cycle(); cycle();
    out_tready = 1'b0;
    #1;
    chk("C_stall_tready", 64'(in_tready), 64'(0));
    chk("C_stall_otdata", 64'(out_tdata), 64'(flit_word(0, 0, 1)));
    for (int s = 0; s < 5; s++) begin
      cycle();
      chk($sformatf("C_hold_otdata%0d", s), 64'(out_tdata), 64'(flit_word(0, 0, 1)));
      chk($sformatf("C_hold_otvalid%0d", s), 64'(out_tvalid), 64'(1));
      chk($sformatf("C_hold_tready%0d", s), 64'(in_tready), 64'(0));
    end
    out_tready = 1'b1;
    repeat (8) cycle();
    for (int f = 0; f < 4; f++) exp_q.push_back(flit_word(0, 0, f));
    chk_stream("C");

    // Single-flit packet from input 2
    do_reset("rstD");
    add_src(2, 1, 1);
    cycle();
    chk("D_grant", 64'(grant), 64'(5'b00100));
    chk("D_locked", 64'(locked), 64'(1));
    cycle();
    chk("D_locked_off", 64'(locked), 64'(0));
    chk("D_otvalid", 64'(out_tvalid), 64'(1));
    chk("D_otlast", 64'(out_tlast), 64'(1));
    chk("D_otid", 64'(out_tid), 64'(2));
    chk("D_otdata", 64'(out_tdata), 64'(flit_word(2, 0, 0)));
    cycle();
    chk("D_drained", 64'(out_tvalid), 64'(0));
    repeat (3) cycle();
    chk("D_locked_cycles", 64'(locked_cycles), 64'(1));
    exp_q.push_back(flit_word(2, 0, 0));
    chk_stream("D");

    // Request and valid drop mid-packet while a rival waits
    do_reset("rstE");
    add_src(0, 4, 1);
    add_src(1, 2, 1);
    cycle(); cycle();
    req_en[0] = 1'b0;
    drive();
    cycle();
    chk("E_noreq_locked", 64'(locked), 64'(1));
    chk("E_noreq_grant", 64'(grant), 64'(5'b00001));
    val_en[0] = 1'b0;
    drive();
    cycle(); cycle();
    chk("E_noval_locked", 64'(locked), 64'(1));
    chk("E_noval_grant", 64'(grant), 64'(5'b00001));
    chk("E_noval_tready", 64'(in_tready), 64'(5'b00001));
    val_en[0] = 1'b1;
    drive();
    repeat (8) cycle();
    chk("E_end_locked", 64'(locked), 64'(0));
    for (int f = 0; f < 4; f++) exp_q.push_back(flit_word(0, 0, f));
    for (int f = 0; f < 2; f++) exp_q.push_back(flit_word(1, 0, f));
    chk_stream("E");

    // Reset mid-packet restores input-0 priority
    do_reset("rstF");
    add_src(0, 1, 1);
    add_src(1, 4, 1);
    repeat (5) cycle();
    chk("F_pre_grant", 64'(grant), 64'(5'b00010));
    chk("F_pre_otdata", 64'(out_tdata), 64'(flit_word(1, 0, 1)));
    rst_n = 1'b0;
    #1;
    chk_zero("F_async");
    clear_src();
    add_src(0, 2, 1);
    add_src(1, 2, 1);
    cycle();
    chk("F_inrst_grant", 64'(grant), 64'(0));
    rst_n = 1'b1;
    cycle();
    chk("F_post_grant", 64'(grant), 64'(5'b00001));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
